// File: rtl/dbg_hwbrk_mc.sv
// ----------------------------------------------------------------------------
// dbg_hwbrk_mc -- multi-channel hardware breakpoint / watchpoint unit
//
// Provides NCH independent channels. Each channel watches either the data
// flow (execution-unit memory bus) or the instruction flow (frontend fetches)
// for an address or address-range match. A per-channel pass counter can
// postpone triggering until a programmed number of hits has been seen.
// Channel results are OR-combined into one halt request and one read bus.
//
// Per-channel register map (select index 6*c+r):
//   r=0 CTL  [6:0] {CNT_EN, DATA_EN, RANGE_MODE, INST_EN, BREAK_EN, ACCESS_MODE[1:0]}
//   r=1 STAT [5:0] {RANGE_WR, RANGE_RD, ADDR1_WR, ADDR1_RD, ADDR0_WR, ADDR0_RD}, W1C
//   r=2 ADDR0, r=3 ADDR1, r=4 DATA, r=5 CNT[CNT_W-1:0]
//
// Optional feature macro: DBG_HWBRK_DATA_EN
//   defined   -> DATA register, CTL[5] and the data comparators are present
//   undefined -> address qualification only; DATA and CTL[5] read as 0
//
// Ports:
//   mclk        main clock
//   por_n       synchronous active-low reset
//   brk_halt    halt request to the debug controller
//   brk_pnd     per-channel "some STAT flag set"
//   brk_dout    register read data (OR of all selected registers)
//   brk_reg_rd  one-hot register read select
//   brk_reg_wr  one-hot register write select
//   dbg_din     register write data
//   eu_mab      execution-unit memory address bus
//   eu_mb_en    execution-unit memory bus enable
//   eu_mb_wr    execution-unit byte write enables
//   eu_mdb_in   memory read data (valid the cycle after the address phase)
//   eu_mdb_out  memory write data
//   exec_done   instruction execution completed
//   fe_mb_en    frontend memory bus enable
//   pc          program counter
// ----------------------------------------------------------------------------
module dbg_hwbrk_mc #(
    parameter int NCH   = 2,
    parameter int CNT_W = 8
) (
    input  logic             mclk,
    input  logic             por_n,
    output logic             brk_halt,
    output logic [NCH-1:0]   brk_pnd,
    output logic [15:0]      brk_dout,
    input  logic [6*NCH-1:0] brk_reg_rd,
    input  logic [6*NCH-1:0] brk_reg_wr,
    input  logic [15:0]      dbg_din,
    input  logic [15:0]      eu_mab,
    input  logic             eu_mb_en,
    input  logic [1:0]       eu_mb_wr,
    input  logic [15:0]      eu_mdb_in,
    input  logic [15:0]      eu_mdb_out,
    input  logic             exec_done,
    input  logic             fe_mb_en,
    input  logic [15:0]      pc
);

`ifdef DBG_HWBRK_DATA_EN
    localparam logic [6:0] CTL_MASK = 7'h7F;
`else
    localparam logic [6:0] CTL_MASK = 7'h5F;
    logic unused_mdb;
    assign unused_mdb = ^{eu_mdb_in, eu_mdb_out};
`endif

    logic                  fe_en_q;
    logic [NCH-1:0][15:0]  dout_ch;
    logic [NCH-1:0]        halt_ch;

    // The fetched word's pc is only meaningful the cycle after the fetch
    // request, so the frontend enable is delayed once and shared by all channels.
    always_ff @(posedge mclk) begin
        if (!por_n) fe_en_q <= 1'b0;
        else        fe_en_q <= fe_mb_en;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [6:0]       ctl;
        logic [5:0]       stat;
        logic [15:0]      addr0;
        logic [15:0]      addr1;
        logic [15:0]      data;
        logic [CNT_W-1:0] cnt;
        logic [2:0]       pend;
        logic [5:0]       wsel;
        logic [5:0]       rsel;
        logic [15:0]      addr;
        logic [2:0]       match;
        logic [2:0]       wr_hit;
        logic [2:0]       rd_acc;
        logic [2:0]       pend_set;
        logic [2:0]       rd_hit;
        logic             data_wr_ok;
        logic [5:0]       rawset;
        logic [5:0]       set;
        logic             cnt_hold;

        assign wsel = brk_reg_wr[6*c +: 6];
        assign rsel = brk_reg_rd[6*c +: 6];

        // Compare slots: 0 = ADDR0, 1 = ADDR1, 2 = range. Only the slots of the
        // selected mode can match; an inverted range never matches.
        assign addr     = ctl[3] ? pc : eu_mab;
        assign match[0] = ~ctl[4] & (addr == addr0);
        assign match[1] = ~ctl[4] & (addr == addr1);
        assign match[2] =  ctl[4] & (addr0 <= addr) & (addr <= addr1);

`ifdef DBG_HWBRK_DATA_EN
        logic [2:0] rd_acc_q;

        // Read data arrives one cycle after the address phase, so the address
        // match is held one cycle to be qualified against the returned data.
        assign data_wr_ok = ~ctl[5] | (eu_mdb_out == data);
        assign pend_set   = ctl[5] ? (rd_acc_q & {3{eu_mdb_in == data}}) : rd_acc;

        always_ff @(posedge mclk) begin
            if (!por_n) begin
                rd_acc_q <= '0;
                data     <= '0;
            end else begin
                rd_acc_q <= rd_acc;
                if (wsel[4]) data <= dbg_din;
            end
        end
`else
        logic unused_data_wr;
        assign unused_data_wr = wsel[4];
        assign data       = '0;
        assign data_wr_ok = 1'b1;
        assign pend_set   = rd_acc;
`endif

        assign wr_hit = {3{~ctl[3] & eu_mb_en & (|eu_mb_wr) & data_wr_ok}} & match;
        assign rd_acc = {3{~ctl[3] & eu_mb_en & ~(|eu_mb_wr)}} & match;

        // Data reads are reported at instruction end so that a read-modify-write
        // on the same compare slot shows up only as a write.
        assign rd_hit = ctl[3] ? ({3{fe_en_q}} & match)
                               : ({3{exec_done}} & pend & ~wr_hit);

        assign rawset = {wr_hit[2] & ctl[1], rd_hit[2] & ctl[0],
                         wr_hit[1] & ctl[1], rd_hit[1] & ctl[0],
                         wr_hit[0] & ctl[1], rd_hit[0] & ctl[0]};

        // While the pass counter is still running, hits only consume a count.
        assign cnt_hold = ctl[6] & (cnt != '0);
        assign set      = cnt_hold ? 6'b0 : rawset;

        // Channel registers; a STAT set beats a simultaneous clear and a CNT
        // write beats a simultaneous decrement.
        always_ff @(posedge mclk) begin
            if (!por_n) begin
                ctl   <= '0;
                stat  <= '0;
                addr0 <= '0;
                addr1 <= '0;
                cnt   <= '0;
                pend  <= '0;
            end else begin
                if (wsel[0]) ctl <= dbg_din[6:0] & CTL_MASK;
                if (wsel[1]) stat <= (stat & ~dbg_din[5:0]) | set;
                else         stat <= stat | set;
                if (wsel[2]) addr0 <= dbg_din;
                if (wsel[3]) addr1 <= dbg_din;
                if (wsel[5])                    cnt <= dbg_din[CNT_W-1:0];
                else if (cnt_hold && |rawset)   cnt <= cnt - CNT_W'(1);
                if (exec_done) pend <= '0;
                else           pend <= pend | pend_set;
            end
        end

        assign dout_ch[c] = ({16{rsel[0]}} & {9'b0, ctl})
                          | ({16{rsel[1]}} & {10'b0, stat})
                          | ({16{rsel[2]}} & addr0)
                          | ({16{rsel[3]}} & addr1)
                          | ({16{rsel[4]}} & data)
                          | ({16{rsel[5]}} & 16'(cnt));

        assign halt_ch[c] = ctl[2] & (|set);
        assign brk_pnd[c] = |stat;
    end

    // Merge all channels onto the shared halt line and read bus.
    always_comb begin
        brk_halt = |halt_ch;
        brk_dout = '0;
        for (int i = 0; i < NCH; i++) brk_dout = brk_dout | dout_ch[i];
    end

endmodule

// File: tb/tb_dbg_hwbrk_mc.sv
// ----------------------------------------------------------------------------
// tb_dbg_hwbrk_mc -- directed self-checking bench for dbg_hwbrk_mc (NCH=2)
// Expected values are hand-computed; DATA-feature expectations follow
// whether DBG_HWBRK_DATA_EN is defined for the build.
// ----------------------------------------------------------------------------
module tb_dbg_hwbrk_mc;
    localparam int NCH   = 2;
    localparam int CNT_W = 8;
    localparam int SELW  = 6 * NCH;

`ifdef DBG_HWBRK_DATA_EN
    localparam bit HAS_DATA = 1'b1;
`else
    localparam bit HAS_DATA = 1'b0;
`endif

    logic             mclk = 1'b0;
    logic             por_n;
    logic             brk_halt;
    logic [NCH-1:0]   brk_pnd;
    logic [15:0]      brk_dout;
    logic [SELW-1:0]  brk_reg_rd;
    logic [SELW-1:0]  brk_reg_wr;
    logic [15:0]      dbg_din;
    logic [15:0]      eu_mab;
    logic             eu_mb_en;
    logic [1:0]       eu_mb_wr;
    logic [15:0]      eu_mdb_in;
    logic [15:0]      eu_mdb_out;
    logic             exec_done;
    logic             fe_mb_en;
    logic [15:0]      pc;

    int n_checks = 0;
    int n_fail   = 0;

    dbg_hwbrk_mc #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .mclk       (mclk),
        .por_n      (por_n),
        .brk_halt   (brk_halt),
        .brk_pnd    (brk_pnd),
        .brk_dout   (brk_dout),
        .brk_reg_rd (brk_reg_rd),
        .brk_reg_wr (brk_reg_wr),
        .dbg_din    (dbg_din),
        .eu_mab     (eu_mab),
        .eu_mb_en   (eu_mb_en),
        .eu_mb_wr   (eu_mb_wr),
        .eu_mdb_in  (eu_mdb_in),
        .eu_mdb_out (eu_mdb_out),
        .exec_done  (exec_done),
        .fe_mb_en   (fe_mb_en),
        .pc         (pc)
    );

    always #5 mclk = ~mclk;

    // Drive point: 1 time unit after each rising edge.
    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input int c, input int r, input logic [15:0] v);
        brk_reg_wr = SELW'(1) << (6*c + r);
        dbg_din    = v;
        tick();
        brk_reg_wr = '0;
        dbg_din    = '0;
    endtask

    task automatic chk_reg(input string tag, input int c, input int r, input logic [15:0] exp);
        brk_reg_rd = SELW'(1) << (6*c + r);
        #1;
        check_output(tag, brk_dout, exp);
        brk_reg_rd = '0;
    endtask

    task automatic apply_stimulus(input logic [15:0] a, input logic [1:0] wr, input logic [15:0] wdata);
        eu_mab     = a;
        eu_mb_en   = 1'b1;
        eu_mb_wr   = wr;
        eu_mdb_out = wdata;
    endtask

    task automatic bus_idle();
        eu_mab     = '0;
        eu_mb_en   = 1'b0;
        eu_mb_wr   = '0;
        eu_mdb_out = '0;
        eu_mdb_in  = '0;
        exec_done  = 1'b0;
    endtask

    // Fetch request one cycle, matching pc presented the next cycle.
    task automatic fetch(input logic [15:0] addr, input logic exp_halt, input string tag);
        fe_mb_en = 1'b1;
        tick();
        fe_mb_en = 1'b0;
        pc       = addr;
        #1;
        check_output(tag, {15'b0, brk_halt}, {15'b0, exp_halt});
        tick();
        pc = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        por_n      = 1'b0;
        brk_reg_rd = '0;
        brk_reg_wr = '0;
        dbg_din    = '0;
        fe_mb_en   = 1'b0;
        pc         = '0;
        bus_idle();

        // Reset state
        tick();
        tick();
        check_output("rst_halt", {15'b0, brk_halt}, 16'h0);
        check_output("rst_pnd", {14'b0, brk_pnd}, 16'h0);
        check_output("rst_dout", brk_dout, 16'h0);
        chk_reg("rst_ctl0", 0, 0, 16'h0);
        por_n = 1'b1;
        tick();

        // 1: data write breakpoint
        reg_wr(0, 0, 16'h0006);
        reg_wr(0, 2, 16'h0200);
        apply_stimulus(16'h0200, 2'b11, 16'h5555);
        #1;
        check_output("t1_halt", {15'b0, brk_halt}, 16'h1);
        tick();
        bus_idle();
        chk_reg("t1_stat0", 0, 1, 16'h0002);
        check_output("t1_pnd", {14'b0, brk_pnd}, 16'h1);
        reg_wr(0, 1, 16'h0002);
        chk_reg("t1_stat0_clr", 0, 1, 16'h0000);
        check_output("t1_pnd_clr", {14'b0, brk_pnd}, 16'h0);

        // 2: range read watch, RMW reports no read
        reg_wr(1, 0, 16'h0011);
        reg_wr(1, 2, 16'h0200);
        reg_wr(1, 3, 16'h020F);
        apply_stimulus(16'h0208, 2'b00, 16'h0);
        tick();
        bus_idle();
        tick();
        apply_stimulus(16'h0208, 2'b11, 16'h0042);
        exec_done = 1'b1;
        tick();
        bus_idle();
        chk_reg("t2_rmw_stat1", 1, 1, 16'h0000);
        apply_stimulus(16'h020F, 2'b00, 16'h0);
        tick();
        bus_idle();
        exec_done = 1'b1;
        chk_reg("t2_before_done", 1, 1, 16'h0000);
        tick();
        bus_idle();
        chk_reg("t2_rd_stat1", 1, 1, 16'h0010);
        check_output("t2_pnd", {14'b0, brk_pnd}, 16'h2);
        reg_wr(1, 1, 16'h0010);
        // inverted range never matches
        reg_wr(1, 2, 16'h0210);
        apply_stimulus(16'h020F, 2'b00, 16'h0);
        tick();
        bus_idle();
        exec_done = 1'b1;
        tick();
        bus_idle();
        chk_reg("t2_inv_range", 1, 1, 16'h0000);

        // 3: instruction breakpoint with pass counter
        reg_wr(0, 0, 16'h004D);
        reg_wr(0, 5, 16'h0003);
        reg_wr(0, 2, 16'hF000);
        fetch(16'hF000, 1'b0, "t3_f1_halt");
        chk_reg("t3_cnt2", 0, 5, 16'h0002);
        fetch(16'hF000, 1'b0, "t3_f2_halt");
        chk_reg("t3_cnt1", 0, 5, 16'h0001);
        fetch(16'hF000, 1'b0, "t3_f3_halt");
        chk_reg("t3_cnt0", 0, 5, 16'h0000);
        chk_reg("t3_stat_quiet", 0, 1, 16'h0000);
        fetch(16'hF000, 1'b1, "t3_f4_halt");
        chk_reg("t3_stat0", 0, 1, 16'h0001);
        chk_reg("t3_cnt_hold", 0, 5, 16'h0000);

        // 4: data value qualifier
        reg_wr(0, 1, 16'h003F);
        reg_wr(0, 0, 16'h0026);
        reg_wr(0, 2, 16'h0300);
        reg_wr(0, 4, 16'h1234);
        chk_reg("t4_ctl0", 0, 0, HAS_DATA ? 16'h0026 : 16'h0006);
        chk_reg("t4_data0", 0, 4, HAS_DATA ? 16'h1234 : 16'h0000);
        apply_stimulus(16'h0300, 2'b11, 16'h1233);
        #1;
        check_output("t4_bad_halt", {15'b0, brk_halt}, HAS_DATA ? 16'h0 : 16'h1);
        tick();
        bus_idle();
        chk_reg("t4_bad_stat", 0, 1, HAS_DATA ? 16'h0000 : 16'h0002);
        reg_wr(0, 1, 16'h003F);
        apply_stimulus(16'h0300, 2'b11, 16'h1234);
        #1;
        check_output("t4_good_halt", {15'b0, brk_halt}, 16'h1);
        tick();
        bus_idle();
        chk_reg("t4_good_stat", 0, 1, 16'h0002);
        reg_wr(0, 1, 16'h003F);
        reg_wr(0, 0, 16'h0025);
        apply_stimulus(16'h0300, 2'b00, 16'h0);
        tick();
        bus_idle();
        eu_mdb_in = 16'h0000;
        tick();
        bus_idle();
        exec_done = 1'b1;
        #1;
        check_output("t4_rdbad_halt", {15'b0, brk_halt}, HAS_DATA ? 16'h0 : 16'h1);
        tick();
        bus_idle();
        chk_reg("t4_rdbad_stat", 0, 1, HAS_DATA ? 16'h0000 : 16'h0001);
        reg_wr(0, 1, 16'h003F);
        apply_stimulus(16'h0300, 2'b00, 16'h0);
        tick();
        bus_idle();
        eu_mdb_in = 16'h1234;
        tick();
        bus_idle();
        exec_done = 1'b1;
        #1;
        check_output("t4_rdgood_halt", {15'b0, brk_halt}, 16'h1);
        tick();
        bus_idle();
        chk_reg("t4_rdgood_stat", 0, 1, 16'h0001);

        // 5: independent channels, set-beats-clear, CNT write beats decrement
        reg_wr(0, 1, 16'h003F);
        reg_wr(0, 0, 16'h0006);
        reg_wr(1, 0, 16'h0002);
        reg_wr(1, 2, 16'h0300);
        apply_stimulus(16'h0300, 2'b01, 16'h0000);
        #1;
        check_output("t5_both_halt", {15'b0, brk_halt}, 16'h1);
        tick();
        bus_idle();
        chk_reg("t5_stat0", 0, 1, 16'h0002);
        chk_reg("t5_stat1", 1, 1, 16'h0002);
        check_output("t5_pnd", {14'b0, brk_pnd}, 16'h3);
        brk_reg_wr = SELW'(1) << 1;
        dbg_din    = 16'h0002;
        apply_stimulus(16'h0300, 2'b11, 16'h0000);
        tick();
        brk_reg_wr = '0;
        dbg_din    = '0;
        bus_idle();
        chk_reg("t5_set_wins", 0, 1, 16'h0002);
        reg_wr(0, 1, 16'h003F);
        reg_wr(1, 1, 16'h003F);
        reg_wr(0, 0, 16'h0046);
        reg_wr(0, 5, 16'h0005);
        brk_reg_wr = SELW'(1) << 5;
        dbg_din    = 16'h0009;
        apply_stimulus(16'h0300, 2'b11, 16'h0000);
        #1;
        check_output("t5_cnt_halt", {15'b0, brk_halt}, 16'h0);
        tick();
        brk_reg_wr = '0;
        dbg_din    = '0;
        bus_idle();
        chk_reg("t5_cnt_load", 0, 5, 16'h0009);
        chk_reg("t5_cnt_stat0", 0, 1, 16'h0000);
        chk_reg("t5_cnt_stat1", 1, 1, 16'h0002);
        reg_wr(1, 0, 16'h0000);

        // 6: reset during pending read and running count
        reg_wr(0, 0, 16'h0041);
        reg_wr(0, 5, 16'h0002);
        apply_stimulus(16'h0300, 2'b00, 16'h0);
        tick();
        bus_idle();
        chk_reg("t6_cnt_pre", 0, 5, 16'h0002);
        por_n = 1'b0;
        tick();
        por_n = 1'b1;
        check_output("t6_halt", {15'b0, brk_halt}, 16'h0);
        check_output("t6_pnd", {14'b0, brk_pnd}, 16'h0);
        chk_reg("t6_ctl0", 0, 0, 16'h0000);
        chk_reg("t6_addr0", 0, 2, 16'h0000);
        chk_reg("t6_cnt0", 0, 5, 16'h0000);
        chk_reg("t6_stat1", 1, 1, 16'h0000);
        reg_wr(0, 0, 16'h0001);
        reg_wr(0, 2, 16'h0300);
        exec_done = 1'b1;
        tick();
        bus_idle();
        chk_reg("t6_no_spurious", 0, 1, 16'h0000);
        apply_stimulus(16'h0300, 2'b00, 16'h0);
        tick();
        bus_idle();
        exec_done = 1'b1;
        tick();
        bus_idle();
        chk_reg("t6_post_read", 0, 1, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
